shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle shift sequencer for the ALU shift path. Captures a 16-bit
//  operand, a 4-bit count and an op code, then drives one 1-bit shift stage
//  per clock until the count is exhausted. Frees the ALU from a full barrel
//  shifter and reports completion with a busy/done handshake.
// PARAMETERS
//  none (datapath fixed at 16 bits, count fixed at 4 bits)
// PORTS
//  clk    in   1   system clock; all state updates on rising edge
//  rst    in   1   synchronous reset, active-high
//  start  in   1   request; sampled only in IDLE
//  In     in   16  operand, captured on the accepting edge
//  Cnt    in   4   shift amount 0..15, captured on the accepting edge
//  Op     in   2   00 ROL, 01 SLL, 10 ROR, 11 SRA; captured on the accepting edge
//  Out    out  16  working/result register; valid when done=1, held until next accept
//  busy   out  1   high in SHIFT and DONE states
//  done   out  1   one-cycle completion pulse
// BEHAVIOUR
//  - Single clock clk; rst is synchronous, active-high. Reset: state=IDLE,
//    Out=16'h0000, busy=0, done=0, remaining count=0. rst overrides start.
//  - States: IDLE, SHIFT, DONE.
//    IDLE : start=1 -> Out<=In, rem<=Cnt, op<=Op; next SHIFT if Cnt!=0 else DONE.
//    SHIFT: each edge applies one 1-bit op to Out, rem<=rem-1; when rem==1
//           (last shift this edge) next DONE.
//    DONE : done=1, busy=1 for exactly one cycle; next IDLE unconditionally.
//  - Latency: accept at edge k; DONE entered at edge k+N (N=Cnt; N=0 -> edge k).
//    done is high in the cycle after that edge. No back-to-back accept:
//    earliest next accept is the edge after DONE.
//  - 1-bit ops on Out: ROL {Out[14:0],Out[15]}; SLL {Out[14:0],1'b0};
//    ROR {Out[0],Out[15:1]}; SRA {Out[15],Out[15:1]} (sign fill).
//  - start while busy is ignored; In/Cnt/Op changes while busy do not affect
//    the operation in flight.
//  - rst in SHIFT or DONE aborts: next cycle all outputs at reset values, no done.
//  - Out is not updated in IDLE except on accept; holds result between ops.
// CONFIGURATION
//  SHIFT_SEQ_SKIP4_EN defined: in SHIFT, when rem>=4 apply a 4-bit shift of the
//   current op in one edge and rem<=rem-4; else 1-bit as above. Latency for
//   N>0 becomes floor(N/4)+(N mod 4) edges. Results identical to base mode.
//  Not defined: strictly 1 bit per SHIFT edge, latency N edges.
// TESTING
//  1. SRA In=16'h8000 Cnt=3 start@k -> done pulse after edge k+3, Out=16'hF000.
//  2. ROL In=16'h8001 Cnt=1 -> Out=16'h0003, busy high 2 cycles, done 1 cycle.
//  3. SLL In=16'hFFFF Cnt=15 -> done after edge k+15, Out=16'h8000;
//     start pulses and In=16'h1234 during busy -> no effect on result.
//  4. ROR In=16'h1234 Cnt=0 -> DONE at accept edge, done next cycle, Out=16'h1234.
//  5. SRA In=16'h8000 Cnt=8, rst at edge k+4 -> Out=0, busy=0, done never pulses;
//     subsequent start accepted normally.
//  6. SHIFT_SEQ_SKIP4_EN: SRA In=16'h8000 Cnt=15 -> done after edge k+6,
//     Out=16'hFFFF; without macro same stimulus -> after edge k+15, same Out.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: captures operand/count/op, then shifts the working
// register one bit per clock (four bits per clock when SHIFT_SEQ_SKIP4_EN is defined).
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   out_q,   out_d;
    logic [CNT_W-1:0]    rem_q,   rem_d;
    logic [1:0]          op_q,    op_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    // One-bit step of the selected operation
    function automatic logic [DATA_W-1:0] shift1(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ROL:  r = {v[14:0], v[15]};
            OP_SLL:  r = {v[14:0], 1'b0};
            OP_ROR:  r = {v[0], v[15:1]};
            default: r = {v[15], v[15:1]};
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_SKIP4_EN
    // Four-bit step, equivalent to four consecutive one-bit steps
    function automatic logic [DATA_W-1:0] shift4(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ROL:  r = {v[11:0], v[15:12]};
            OP_SLL:  r = {v[11:0], 4'b0000};
            OP_ROR:  r = {v[3:0], v[15:4]};
            default: r = {{4{v[15]}}, v[15:4]};
        endcase
        return r;
    endfunction
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    out_d   = In;
                    rem_d   = Cnt;
                    op_d    = Op;
                    state_d = (Cnt != CNT_W'(0)) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
`ifdef SHIFT_SEQ_SKIP4_EN
                if (rem_q >= CNT_W'(4)) begin
                    out_d = shift4(op_q, out_q);
                    rem_d = rem_q - CNT_W'(4);
                end else begin
                    out_d = shift1(op_q, out_q);
                    rem_d = rem_q - CNT_W'(1);
                end
`else
                out_d = shift1(op_q, out_q);
                rem_d = rem_q - CNT_W'(1);
`endif
                if (rem_d == CNT_W'(0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_ROL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: table of operations plus hand-written
// noise-during-busy and reset-abort sequences. Latency follows SHIFT_SEQ_SKIP4_EN.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] n);
`ifdef SHIFT_SEQ_SKIP4_EN
        return int'(n) / 4 + int'(n) % 4;
`else
        return int'(n);
`endif
    endfunction

    // Issue one operation at a negedge, measure edges to DONE, check result and hold
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] din,
                          input logic [3:0] cnt, input logic [15:0] exp_out, input bit noisy);
        int  c;
        bit  got;
        bit  busy_ok;
        @(negedge clk);
        start = 1'b1; In = din; Cnt = cnt; Op = op;
        @(posedge clk);
        c = 0; got = 1'b0; busy_ok = 1'b1;
        while (c < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noisy) begin
                start = 1'($urandom_range(1, 0));
                In    = 16'h1234;
                Cnt   = 4'($urandom_range(15, 0));
                Op    = 2'($urandom_range(3, 0));
            end else begin
                start = 1'b0;
            end
            c++;
        end
        start = 1'b0;
        if (!got) begin
            check({tag, "_timeout"}, 1, 0);
        end else begin
            check({tag, "_latency"}, c, exp_lat(cnt));
            check({tag, "_out"}, int'(Out), int'(exp_out));
            check({tag, "_busy_at_done"}, int'(busy), 1);
            check({tag, "_busy_while_shifting"}, int'(busy_ok), 1);
            In = ~din;
            @(negedge clk);
            check({tag, "_done_one_cycle"}, int'(done), 0);
            check({tag, "_idle_busy"}, int'(busy), 0);
            check({tag, "_hold_out"}, int'(Out), int'(exp_out));
        end
    endtask

    initial begin
        bit seen_done;

        vecs[0]  = '{2'b11, 16'h8000, 4'd3,  16'hF000};
        vecs[1]  = '{2'b00, 16'h8001, 4'd1,  16'h0003};
        vecs[2]  = '{2'b01, 16'hFFFF, 4'd15, 16'h8000};
        vecs[3]  = '{2'b10, 16'h1234, 4'd0,  16'h1234};
        vecs[4]  = '{2'b10, 16'h1234, 4'd4,  16'h4123};
        vecs[5]  = '{2'b01, 16'h0001, 4'd4,  16'h0010};
        vecs[6]  = '{2'b00, 16'h1234, 4'd8,  16'h3412};
        vecs[7]  = '{2'b11, 16'h7FF0, 4'd4,  16'h07FF};
        vecs[8]  = '{2'b11, 16'h8000, 4'd15, 16'hFFFF};
        vecs[9]  = '{2'b10, 16'h0001, 4'd1,  16'h8000};
        vecs[10] = '{2'b01, 16'h00FF, 4'd7,  16'h7F80};
        vecs[11] = '{2'b00, 16'h8421, 4'd5,  16'h8430};

        rst = 1'b1; start = 1'b1; In = 16'hABCD; Cnt = 4'd2; Op = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", int'(Out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].cnt,
                   vecs[i].exp_out, 1'b0);
        end

        // Start pulses and operand changes while busy must not disturb the result
        run_op("sll15_noisy", 2'b01, 16'hFFFF, 4'd15, 16'h8000, 1'b1);

        // Reset mid-shift aborts without a done pulse
        @(negedge clk);
        start = 1'b1; In = 16'h8000; Cnt = 4'd8; Op = 2'b11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out", int'(Out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", int'(seen_done), 0);
        check("abort_out_held", int'(Out), 0);
        run_op("after_abort", 2'b00, 16'h8001, 4'd1, 16'h0003, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
